scff_scan_ctrl: RTL and testbench
=================================

Name: scff_scan_ctrl

Overview:
- On-chip sequencer for the FPGA fabric scan chain (sc_head → sc_tail).
- Runs a full integrity test without the testbench: raises Test_en, flushes the chain with zeros, injects a single '1', watches for it at sc_tail, then checks trailing zeros.
- Sits between the management logic-analyzer/Wishbone registers and the fabric scan pins. Reports pass/fail, error count and the observed pulse position.

Parameters:
- SCANCHAIN_SIZE, 1024, number of scan flops between sc_head and sc_tail.
- TAIL_LAT, 0, extra register stages on the sc_tail return path (0..3).
- ARM_CYCLES, 2, cycles Test_en is held before the first shift clock.
- CHECK_ZEROS, 2, cycles checked for '0' after the expected pulse.
- CNT_W, 11, counter width; must hold SCANCHAIN_SIZE+TAIL_LAT+CHECK_ZEROS.

Ports:
- clock  in  1  single clock; the fabric op_clk domain.
- resetb  in  1  synchronous active-low reset.
- start  in  1  1-cycle request; honoured only in IDLE.
- abort  in  1  level; forces the sequence to stop.
- sc_tail  in  1  scan-chain tail.
- sc_head  out  1  scan-chain head drive.
- sc_clk_en  out  1  gate for the fabric scan clock.
- test_en  out  1  fabric Test_en.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle completion pulse.
- pass  out  1  result of the last run; valid from done.
- aborted  out  1  last run was aborted.
- no_pulse  out  1  no '1' seen at sc_tail during SHIFT.
- err_count  out  8  mismatch count, saturating at 255.
- pulse_pos  out  CNT_W  k index of the first sc_tail=1 in SHIFT; all-ones if none.

Behaviour:
- Reset (resetb=0 at a clock edge): state IDLE; every output 0, except pulse_pos = all-ones. Reset wins over all other inputs, including mid-run; no done pulse is issued.
- All outputs are registered. sc_tail is sampled directly; TAIL_LAT covers external stages.
- Define EXP = SCANCHAIN_SIZE + TAIL_LAT and END = EXP + CHECK_ZEROS.
- IDLE:
  - start=1 → ARM.
  - On entry to ARM: clear err_count, clear pass/aborted/no_pulse, set pulse_pos to all-ones, set cnt=0.
- ARM:
  - test_en=1, sc_clk_en=0, sc_head=0.
  - After ARM_CYCLES cycles → FLUSH with cnt=0.
- FLUSH:
  - test_en=1, sc_clk_en=1, sc_head=0.
  - Lasts EXP cycles; no checking → SHIFT with k=0.
- SHIFT:
  - test_en=1, sc_clk_en=1.
  - sc_head=1 only in cycle k=0, else 0.
  - Each cycle, sample sc_tail against the expected value: 1 iff k==EXP.
  - Mismatch → err_count+1 (saturating).
  - First sample equal to 1 → pulse_pos=k.
  - After the sample at k==END → DONE.
- DONE (1 cycle):
  - done=1.
  - pass = (err_count==0).
  - no_pulse = (pulse_pos all-ones).
  - test_en=0, sc_clk_en=0 → IDLE.
- abort=1 in ARM/FLUSH/SHIFT:
  - Next state DONE with aborted=1, pass=0.
  - sc_clk_en and test_en drop in the DONE cycle.
  - Error counters keep partial values.
- Other control rules:
  - start is ignored while busy.
  - abort in IDLE is ignored.
  - start and abort together in IDLE: abort wins (stay IDLE).
- Counter wrap is impossible by CNT_W sizing; the sizing rule is enforced by an elaboration-time check.
- Run length with no abort: start edge → done = 1 + ARM_CYCLES + EXP + END + 1 cycles.
- Result outputs (pass, aborted, no_pulse, err_count, pulse_pos) hold until the next accepted start.

Test Plan:
- Ideal 1024-flop chain model gated by sc_clk_en, default params, start → done after 2054 cycles: pass=1, err_count=0, pulse_pos=1024, no_pulse=0, test_en high for the whole run.
- Chain model of 1023 flops → pulse_pos=1023, err_count=2 (k=1023 and k=1024), pass=0.
- sc_tail stuck at 1 → pulse_pos=0, err_count=255 (saturated), pass=0.
- sc_tail stuck at 0 → no_pulse=1, pulse_pos=all-ones, err_count=1, pass=0.
- abort asserted at SHIFT k=500 → done 1 cycle later with aborted=1, pass=0; sc_clk_en=0 from the done cycle onward. A second start during busy is ignored.
- resetb low for 1 cycle at FLUSH cnt=300 → next cycle all outputs at reset values, no done pulse; a subsequent start runs a full pass.

Source files
------------

// File: rtl/scff_scan_ctrl.sv
// scff_scan_ctrl: on-chip integrity sequencer for the fabric scan chain.
// Raises Test_en, flushes the chain with zeros, injects a single '1' at
// sc_head and checks that it emerges at sc_tail exactly EXP shift clocks
// later, followed by CHECK_ZEROS zeros. All outputs are registered.
module scff_scan_ctrl #(
    parameter int SCANCHAIN_SIZE = 1024,
    parameter int TAIL_LAT       = 0,
    parameter int ARM_CYCLES     = 2,
    parameter int CHECK_ZEROS    = 2,
    parameter int CNT_W          = 11
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             start,
    input  logic             abort,
    input  logic             sc_tail,
    output logic             sc_head,
    output logic             sc_clk_en,
    output logic             test_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic             no_pulse,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] pulse_pos
);

    // Expected arrival index of the injected '1' and index of the last sample.
    localparam int EXP    = SCANCHAIN_SIZE + TAIL_LAT;
    localparam int LAST_K = EXP + CHECK_ZEROS;

    localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(EXP - 1);
    localparam logic [CNT_W-1:0] EXP_K      = CNT_W'(EXP);
    localparam logic [CNT_W-1:0] END_K      = CNT_W'(LAST_K);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] POS_NONE   = {CNT_W{1'b1}};

    // The counter must never wrap: it has to hold the last sample index.
    if (LAST_K > (2 ** CNT_W) - 1) begin : g_cnt_w_too_small
        $error("scff_scan_ctrl: CNT_W cannot hold SCANCHAIN_SIZE+TAIL_LAT+CHECK_ZEROS");
    end
    if ((ARM_CYCLES < 1) || (TAIL_LAT < 0) || (TAIL_LAT > 3) || (SCANCHAIN_SIZE < 1)) begin : g_bad_params
        $error("scff_scan_ctrl: ARM_CYCLES>=1, 0<=TAIL_LAT<=3 and SCANCHAIN_SIZE>=1 required");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             seen_r;
    logic             seen_nxt_s;
    logic             expect_s;
    logic [7:0]       err_nxt_s;
    logic [CNT_W-1:0] pos_nxt_s;
    logic             pass_nxt_s;
    logic             aborted_nxt_s;
    logic             no_pulse_nxt_s;
    logic             head_nxt_s;
    logic             clk_en_nxt_s;
    logic             test_en_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    // Error counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // Next-state, counter and result bookkeeping.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        seen_nxt_s     = seen_r;
        err_nxt_s      = err_count;
        pos_nxt_s      = pulse_pos;
        pass_nxt_s     = pass;
        aborted_nxt_s  = aborted;
        no_pulse_nxt_s = no_pulse;
        expect_s       = (cnt_r == EXP_K);
        case (state_r)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_nxt_s    = ST_ARM;
                    cnt_nxt_s      = CNT_ZERO;
                    seen_nxt_s     = 1'b0;
                    err_nxt_s      = 8'd0;
                    pos_nxt_s      = POS_NONE;
                    pass_nxt_s     = 1'b0;
                    aborted_nxt_s  = 1'b0;
                    no_pulse_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_nxt_s    = ST_DONE;
                    aborted_nxt_s  = 1'b1;
                    pass_nxt_s     = 1'b0;
                    no_pulse_nxt_s = !seen_r;
                end else if (cnt_r == ARM_LAST) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_nxt_s    = ST_DONE;
                    aborted_nxt_s  = 1'b1;
                    pass_nxt_s     = 1'b0;
                    no_pulse_nxt_s = !seen_r;
                end else if (cnt_r == FLUSH_LAST) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt_s    = ST_DONE;
                    aborted_nxt_s  = 1'b1;
                    pass_nxt_s     = 1'b0;
                    no_pulse_nxt_s = !seen_r;
                end else begin
                    if (sc_tail != expect_s) begin
                        err_nxt_s = sat_inc(err_count);
                    end else begin
                        err_nxt_s = err_count;
                    end
                    if (sc_tail && !seen_r) begin
                        pos_nxt_s  = cnt_r;
                        seen_nxt_s = 1'b1;
                    end else begin
                        pos_nxt_s = pulse_pos;
                    end
                    // results become valid together with the done pulse
                    if (cnt_r == END_K) begin
                        state_nxt_s    = ST_DONE;
                        pass_nxt_s     = (err_nxt_s == 8'd0);
                        no_pulse_nxt_s = !seen_nxt_s;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pin-level controls decoded from the state being entered, so the
    // registered outputs line up with the state register.
    always_comb begin
        head_nxt_s    = 1'b0;
        clk_en_nxt_s  = 1'b0;
        test_en_nxt_s = 1'b0;
        busy_nxt_s    = 1'b1;
        done_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_ARM: begin
                test_en_nxt_s = 1'b1;
            end
            ST_FLUSH: begin
                test_en_nxt_s = 1'b1;
                clk_en_nxt_s  = 1'b1;
            end
            ST_SHIFT: begin
                test_en_nxt_s = 1'b1;
                clk_en_nxt_s  = 1'b1;
                head_nxt_s    = (cnt_nxt_s == CNT_ZERO);
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            seen_r    <= 1'b0;
            sc_head   <= 1'b0;
            sc_clk_en <= 1'b0;
            test_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            aborted   <= 1'b0;
            no_pulse  <= 1'b0;
            err_count <= 8'd0;
            pulse_pos <= POS_NONE;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            seen_r    <= seen_nxt_s;
            sc_head   <= head_nxt_s;
            sc_clk_en <= clk_en_nxt_s;
            test_en   <= test_en_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
            pass      <= pass_nxt_s;
            aborted   <= aborted_nxt_s;
            no_pulse  <= no_pulse_nxt_s;
            err_count <= err_nxt_s;
            pulse_pos <= pos_nxt_s;
        end
    end

endmodule

// File: tb/tb_scff_scan_ctrl.sv
// Bench for scff_scan_ctrl: scan-chain model driven by sc_head/sc_clk_en,
// table-driven chain/stuck-at scenarios, hand-written abort/reset sequences
// and randomized tail traffic checked against a sample-list reference model.
module tb_scff_scan_ctrl;

    localparam int N          = 1024;
    localparam int TL         = 0;
    localparam int ARM        = 2;
    localparam int CZ         = 2;
    localparam int CW         = 11;
    localparam int EXP        = N + TL;
    localparam int ENDK       = EXP + CZ;
    // negedge index (start-sampling edge = edge 0) of SHIFT cycle k=0
    localparam int SHIFT_IDX0 = ARM + EXP + 1;
    // negedge index at which done is visible for a full run
    localparam int RUN_LEN    = 1 + ARM + EXP + ENDK + 1;
    localparam int POS_NONE   = (1 << CW) - 1;
    localparam int CHAIN_MAX  = 1040;

    logic          clock;
    logic          resetb;
    logic          start;
    logic          abort;
    logic          sc_tail;
    logic          sc_head;
    logic          sc_clk_en;
    logic          test_en;
    logic          busy;
    logic          done;
    logic          pass;
    logic          aborted;
    logic          no_pulse;
    logic [7:0]    err_count;
    logic [CW-1:0] pulse_pos;

    int n_checks = 0;
    int n_fails  = 0;

    // tail source: 0 = chain model, 1 = stuck 0, 2 = stuck 1, 3 = random bits
    int mode = 0;
    int len  = N;
    int dens = 100;
    bit chain [0:CHAIN_MAX-1];
    bit rnd_bit;

    bit tails_q[$];
    int done_idx;
    int te_low;

    scff_scan_ctrl #(
        .SCANCHAIN_SIZE(N),
        .TAIL_LAT      (TL),
        .ARM_CYCLES    (ARM),
        .CHECK_ZEROS   (CZ),
        .CNT_W         (CW)
    ) dut (
        .clock    (clock),
        .resetb   (resetb),
        .start    (start),
        .abort    (abort),
        .sc_tail  (sc_tail),
        .sc_head  (sc_head),
        .sc_clk_en(sc_clk_en),
        .test_en  (test_en),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .aborted  (aborted),
        .no_pulse (no_pulse),
        .err_count(err_count),
        .pulse_pos(pulse_pos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fabric scan chain: shifts only when the scan clock gate is open.
    always @(posedge clock) begin
        if (sc_clk_en) begin
            chain[0] <= sc_head;
            for (int i = 1; i < CHAIN_MAX; i++) chain[i] <= chain[i-1];
        end
        rnd_bit <= ($urandom_range(0, dens - 1) == 0);
    end

    assign sc_tail = (mode == 0) ? chain[len-1] :
                     (mode == 1) ? 1'b0 :
                     (mode == 2) ? 1'b1 : rnd_bit;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".sc_head"},   int'(sc_head),   0);
        chk({tag, ".sc_clk_en"}, int'(sc_clk_en), 0);
        chk({tag, ".test_en"},   int'(test_en),   0);
        chk({tag, ".busy"},      int'(busy),      0);
        chk({tag, ".done"},      int'(done),      0);
        chk({tag, ".pass"},      int'(pass),      0);
        chk({tag, ".aborted"},   int'(aborted),   0);
        chk({tag, ".no_pulse"},  int'(no_pulse),  0);
        chk({tag, ".err_count"}, int'(err_count), 0);
        chk({tag, ".pulse_pos"}, int'(pulse_pos), POS_NONE);
    endtask

    task automatic chk_results(input string tag, input int e_pass, input int e_abt,
                               input int e_np, input int e_err, input int e_pos);
        chk({tag, ".done"},      int'(done),      1);
        chk({tag, ".pass"},      int'(pass),      e_pass);
        chk({tag, ".aborted"},   int'(aborted),   e_abt);
        chk({tag, ".no_pulse"},  int'(no_pulse),  e_np);
        chk({tag, ".err_count"}, int'(err_count), e_err);
        chk({tag, ".pulse_pos"}, int'(pulse_pos), e_pos);
    endtask

    // Pulse start from a negedge, then follow the run negedge by negedge until
    // done shows up. Records sc_tail over the sample window, counts cycles
    // with test_en low, optionally raises abort in SHIFT cycle abort_k and a
    // stray start at negedge extra_start_i. Returns sitting on the done negedge.
    task automatic launch(input int abort_k, input int extra_start_i);
        tails_q.delete();
        done_idx = -1;
        te_low   = 0;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 1; i <= RUN_LEN + 16; i++) begin
            abort = (abort_k >= 0) && (i == SHIFT_IDX0 + abort_k);
            start = (i == extra_start_i);
            if (done === 1'b1) begin
                done_idx = i;
                break;
            end
            if (test_en !== 1'b1) te_low++;
            if ((i >= SHIFT_IDX0) && (i <= SHIFT_IDX0 + ENDK)) tails_q.push_back(sc_tail);
            @(negedge clock);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    // Reference: k-th recorded sample should be 1 exactly when k == EXP.
    task automatic model(output int m_pass, output int m_err, output int m_pos, output int m_np);
        m_err = 0;
        m_pos = -1;
        foreach (tails_q[k]) begin
            if (tails_q[k] != (k == EXP)) m_err++;
            if (tails_q[k] && (m_pos < 0)) m_pos = k;
        end
        m_pass = (m_err == 0) ? 1 : 0;
        if (m_err > 255) m_err = 255;
        m_np = (m_pos < 0) ? 1 : 0;
        if (m_pos < 0) m_pos = POS_NONE;
    endtask

    typedef struct {
        int mode;
        int len;
        int pass;
        int err;
        int pos;
        int np;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int m_pass, m_err, m_pos, m_np, hits;
        string tag;

        vecs[0] = '{mode: 0, len: 1024, pass: 1, err: 0,   pos: 1024,     np: 0};
        vecs[1] = '{mode: 0, len: 1023, pass: 0, err: 2,   pos: 1023,     np: 0};
        vecs[2] = '{mode: 2, len: 1024, pass: 0, err: 255, pos: 0,        np: 0};
        vecs[3] = '{mode: 1, len: 1024, pass: 0, err: 1,   pos: POS_NONE, np: 1};

        resetb = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset("reset");
        resetb = 1'b1;
        @(negedge clock);
        chk("idle.busy", int'(busy), 0);

        // start and abort together in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort.busy", int'(busy), 0);
        repeat (3) @(negedge clock);
        chk("start_abort.test_en", int'(test_en), 0);
        // abort alone in IDLE is ignored
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("idle_abort.busy", int'(busy), 0);
        chk("idle_abort.aborted", int'(aborted), 0);

        // table-driven full runs
        for (int v = 0; v < 4; v++) begin
            tag  = $sformatf("vec%0d", v);
            mode = vecs[v].mode;
            len  = vecs[v].len;
            launch(-1, 600);
            chk({tag, ".done_idx"}, done_idx, RUN_LEN);
            chk({tag, ".te_low"}, te_low, 0);
            chk_results(tag, vecs[v].pass, 0, vecs[v].np, vecs[v].err, vecs[v].pos);
            @(negedge clock);
            chk({tag, ".done_after"}, int'(done), 0);
            chk({tag, ".busy_after"}, int'(busy), 0);
            chk({tag, ".err_hold"}, int'(err_count), vecs[v].err);
        end

        // abort at SHIFT k=500 with a stray start during FLUSH
        mode = 0;
        len  = N;
        launch(500, 400);
        chk("abort.done_idx", done_idx, SHIFT_IDX0 + 501);
        chk("abort.sc_clk_en", int'(sc_clk_en), 0);
        chk("abort.test_en", int'(test_en), 0);
        chk_results("abort", 0, 1, 1, 0, POS_NONE);
        @(negedge clock);
        chk("abort.sc_clk_en_after", int'(sc_clk_en), 0);
        hits = 0;
        repeat (6) begin
            if (busy !== 1'b0) hits++;
            @(negedge clock);
        end
        chk("abort.no_restart", hits, 0);
        chk("abort.aborted_hold", int'(aborted), 1);

        // reset for one cycle at FLUSH cnt=300
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (302) @(negedge clock);
        chk("mid_reset.in_flush", int'(sc_clk_en), 1);
        resetb = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        chk_reset("mid_reset");
        hits = 0;
        repeat (20) begin
            @(negedge clock);
            if ((done !== 1'b0) || (busy !== 1'b0)) hits++;
        end
        chk("mid_reset.quiet", hits, 0);
        launch(-1, -1);
        chk("post_reset.done_idx", done_idx, RUN_LEN);
        chk_results("post_reset", 1, 0, 0, 0, 1024);

        // randomized chain lengths and random tail traffic vs the model
        for (int r = 0; r < 4; r++) begin
            tag = $sformatf("rnd%0d", r);
            if ((r % 2) == 0) begin
                mode = 0;
                len  = $urandom_range(1018, 1030);
            end else begin
                mode = 3;
                dens = (r == 1) ? 3 : $urandom_range(50, 400);
            end
            repeat ($urandom_range(0, 5)) @(negedge clock);
            launch(-1, -1);
            model(m_pass, m_err, m_pos, m_np);
            chk({tag, ".done_idx"}, done_idx, RUN_LEN);
            chk({tag, ".samples"}, tails_q.size(), ENDK + 1);
            chk_results(tag, m_pass, 0, m_np, m_err, m_pos);
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

endmodule
